// File: rtl/miner_pkg.sv
// Shared definitions for the miner header-load path.
package miner_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MID  = 2'b01,
    TAIL = 2'b10,
    DONE = 2'b11
  } shift_phase_t;

  localparam int unsigned HDR_MID_WORDS  = 8;
  localparam int unsigned HDR_TAIL_WORDS = 16;

endpackage : miner_pkg

// File: rtl/shift_word_counter.sv
// Word counter with synchronous clear and enable; saturates instead of rolling over.
module shift_word_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule : shift_word_counter

// File: rtl/header_shift_timer.sv
// Phase timer for loading a block header into the SHA-256 core: counts accepted
// words and flags the end of the midstate and remaining-word phases.
module header_shift_timer
  import miner_pkg::*;
#(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned MID_WORDS   = HDR_MID_WORDS,
  parameter int unsigned TAIL_WORDS  = HDR_TAIL_WORDS,
  parameter int unsigned LEVEL_FLAGS = 0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             shift_in_enable,
  output logic             midstate_shifts_done,
  output logic             remaining_shifts_done,
  output logic             load_busy,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] word_count,
  output logic             extra_word_err
);

  localparam int unsigned TOTAL_WORDS = MID_WORDS + TAIL_WORDS;
  localparam logic [CNT_W-1:0] MID_LAST   = CNT_W'(MID_WORDS - 1);
  localparam logic [CNT_W-1:0] TOTAL_LAST = CNT_W'(TOTAL_WORDS - 1);

  // Reject configurations where the counter could not hold the full load.
  if ((64'd1 << CNT_W) <= 64'(TOTAL_WORDS)) begin : g_bad_cnt_w
    $error("header_shift_timer: CNT_W too narrow for MID_WORDS+TAIL_WORDS");
  end
  if ((MID_WORDS < 1) || (TAIL_WORDS < 1)) begin : g_bad_words
    $error("header_shift_timer: MID_WORDS and TAIL_WORDS must be >= 1");
  end

  shift_phase_t state_q, state_d;
  logic cnt_clr, cnt_en;
  logic mid_set, rem_set, err_set, flag_clr;
  logic mid_done_q, rem_done_q, err_q, busy_q;

  shift_word_counter #(.W(CNT_W)) u_word_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (word_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: abort > start > shift_in_enable; a word in the start cycle is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    mid_set  = 1'b0;
    rem_set  = 1'b0;
    err_set  = 1'b0;
    flag_clr = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      cnt_clr  = 1'b1;
      flag_clr = 1'b1;
    end else if (start) begin
      state_d  = MID;
      cnt_clr  = 1'b1;
      flag_clr = 1'b1;
    end else if (shift_in_enable) begin
      case (state_q)
        MID: begin
          cnt_en = 1'b1;
          if (word_count == MID_LAST) begin
            state_d = TAIL;
            mid_set = 1'b1;
          end
        end
        TAIL: begin
          cnt_en = 1'b1;
          if (word_count == TOTAL_LAST) begin
            state_d = DONE;
            rem_set = 1'b1;
          end
        end
        DONE:    err_set = 1'b1;
        default: ;
      endcase
    end
  end

  // Done flags: pulse mode clears every cycle, level mode holds until start/abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mid_done_q <= 1'b0;
      rem_done_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_d == MID) || (state_d == TAIL);
      if (flag_clr) begin
        mid_done_q <= 1'b0;
        rem_done_q <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        if (mid_set) begin
          mid_done_q <= 1'b1;
        end else if (LEVEL_FLAGS == 0) begin
          mid_done_q <= 1'b0;
        end
        if (rem_set) begin
          rem_done_q <= 1'b1;
        end else if (LEVEL_FLAGS == 0) begin
          rem_done_q <= 1'b0;
        end
        if (err_set) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign midstate_shifts_done  = mid_done_q;
  assign remaining_shifts_done = rem_done_q;
  assign extra_word_err        = err_q;
  assign load_busy             = busy_q;
  assign phase                 = state_q;

endmodule : header_shift_timer

// File: tb/tb_header_shift_timer.sv
// Directed bench: a default (pulse) instance and a small level-flag instance share
// stimulus; a reference model pushes expected outputs that are popped after each edge.
module tb_header_shift_timer;

  logic clk = 1'b0;
  logic n_rst, start, abort, shift_in_enable;

  logic       a_md, a_rd, a_busy, a_err;
  logic [1:0] a_phase;
  logic [4:0] a_wc;
  logic       b_md, b_rd, b_busy, b_err;
  logic [1:0] b_phase;
  logic [3:0] b_wc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  phase;
    logic [31:0] cnt;
    logic        md;
    logic        rd;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t ma, mb, rst_exp;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  header_shift_timer dut_a (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .shift_in_enable(shift_in_enable),
    .midstate_shifts_done(a_md), .remaining_shifts_done(a_rd),
    .load_busy(a_busy), .phase(a_phase), .word_count(a_wc),
    .extra_word_err(a_err)
  );

  header_shift_timer #(.CNT_W(4), .MID_WORDS(4), .TAIL_WORDS(4), .LEVEL_FLAGS(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .shift_in_enable(shift_in_enable),
    .midstate_shifts_done(b_md), .remaining_shifts_done(b_rd),
    .load_busy(b_busy), .phase(b_phase), .word_count(b_wc),
    .extra_word_err(b_err)
  );

  // Reference model of one clock edge for a given configuration.
  function automatic exp_t model_step(exp_t c, logic s, logic a, logic e,
                                      int unsigned mid, int unsigned tail, bit level);
    exp_t n = c;
    if (!level) begin
      n.md = 1'b0;
      n.rd = 1'b0;
    end
    if (a) begin
      n.phase = 2'b00; n.cnt = 0; n.md = 0; n.rd = 0; n.err = 0;
    end else if (s) begin
      n.phase = 2'b01; n.cnt = 0; n.md = 0; n.rd = 0; n.err = 0;
    end else if (e) begin
      if (c.phase == 2'b01) begin
        n.cnt = c.cnt + 1;
        if (n.cnt == mid) begin n.phase = 2'b10; n.md = 1'b1; end
      end else if (c.phase == 2'b10) begin
        n.cnt = c.cnt + 1;
        if (n.cnt == mid + tail) begin n.phase = 2'b11; n.rd = 1'b1; end
      end else if (c.phase == 2'b11) begin
        n.err = 1'b1;
      end
    end
    n.busy = (n.phase == 2'b01) || (n.phase == 2'b10);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    exp_t ea, eb;
    checks++;
    assert ((qa.size() > 0) && (qb.size() > 0)) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", qa.size());
    end
    if ((qa.size() == 0) || (qb.size() == 0)) return;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("a_phase", 32'(a_phase), 32'(ea.phase));
    chk("a_count", 32'(a_wc),    ea.cnt);
    chk("a_mid",   32'(a_md),    32'(ea.md));
    chk("a_rem",   32'(a_rd),    32'(ea.rd));
    chk("a_busy",  32'(a_busy),  32'(ea.busy));
    chk("a_err",   32'(a_err),   32'(ea.err));
    chk("b_phase", 32'(b_phase), 32'(eb.phase));
    chk("b_count", 32'(b_wc),    eb.cnt);
    chk("b_mid",   32'(b_md),    32'(eb.md));
    chk("b_rem",   32'(b_rd),    32'(eb.rd));
    chk("b_busy",  32'(b_busy),  32'(eb.busy));
    chk("b_err",   32'(b_err),   32'(eb.err));
  endtask

  task automatic step(input logic s, input logic a, input logic e);
    start = s; abort = a; shift_in_enable = e;
    ma = model_step(ma, s, a, e, 8, 16, 1'b0);
    mb = model_step(mb, s, a, e, 4, 4, 1'b1);
    qa.push_back(ma);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_exp = '{phase: 2'b00, cnt: 0, md: 0, rd: 0, busy: 0, err: 0};
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; shift_in_enable = 1'b0;
    ma = rst_exp; mb = rst_exp;
    #12;
    qa.push_back(ma); qb.push_back(mb);
    compare_all();
    n_rst = 1'b1;

    // 1: back-to-back full load
    step(1, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);

    // 2: words on alternate cycles
    step(1, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end

    // 3: abort mid-load, then a clean load
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 0, 1);

    // 4: surplus word in DONE is sticky until the next start
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);

    // 5: start-cycle word dropped, restart, abort beats start
    step(1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 0, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    step(0, 0, 0);

    // Level flags held into DONE, then dropped by abort
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    step(0, 1, 0);

    // Reset asserted mid-load takes effect without a clock edge
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    #2 n_rst = 1'b0;
    #1;
    ma = rst_exp; mb = rst_exp;
    qa.push_back(ma); qb.push_back(mb);
    compare_all();
    @(negedge clk);
    n_rst = 1'b1;
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_header_shift_timer
